// File: rtl/sync_fifo_flags_pkg.sv
// sync_fifo_flags_pkg: shared FIFO constants and the depth legality check
package sync_fifo_flags_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AE_LEVEL   = 2;
  localparam int MIN_DEPTH      = 4;
  // Pointers wrap by truncation, so the depth must be a power of two.
  function automatic bit depth_ok(input int d);
    return (d >= MIN_DEPTH) && ((d & (d - 1)) == 0);
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: register array with synchronous write and asynchronous read
module sync_fifo_mem
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags, sticky errors and optional FWFT
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and at least 4");
  end

  logic [CW-1:0]         r_wptr, r_rptr, r_count, w_count_next;
  logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic [DATA_WIDTH-1:0] r_dout, w_rdata;
  logic                  w_wr_acc, w_rd_acc;

  assign w_wr_acc     = w_en & ~r_full;
  assign w_rd_acc     = r_en & ~r_empty;
  assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wptr[PTR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (r_rptr[PTR_WIDTH-1:0]),
    .rdata (w_rdata)
  );

  // Pointers, occupancy and flags all advance from the next count so they agree on every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
    end else begin
      r_wptr  <= r_wptr + CW'(w_wr_acc);
      r_rptr  <= r_rptr + CW'(w_rd_acc);
      r_count <= w_count_next;
      r_full  <= w_count_next == DEPTH_C;
      r_empty <= w_count_next == '0;
      r_af    <= w_count_next >= AF_C;
      r_ae    <= w_count_next <= AE_C;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (w_en & r_full) | (r_ovf & ~clr_err);
      r_unf <= (r_en & r_empty) | (r_unf & ~clr_err);
    end
  end

  // Registered read data for standard mode, held when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) r_dout <= '0;
    else if (w_rd_acc) r_dout <= w_rdata;
  end

  assign data_out     = (FWFT != 0) ? w_rdata : r_dout;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed and random checks of both read modes against a queue model
module tb_sync_fifo_flags;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n, w_en, r_en, clr_err;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout0, dout1;
  logic full0, empty0, af0, ae0, ovf0, unf0;
  logic full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0),
    .clr_err(clr_err));

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1),
    .clr_err(clr_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count0", 32'(cnt0), 32'(n));
    chk("count1", 32'(cnt1), 32'(n));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("full0", 32'(full0), 32'(n == DEPTH));
    chk("full1", 32'(full1), 32'(n == DEPTH));
    chk("afull0", 32'(af0), 32'(n >= AF));
    chk("afull1", 32'(af1), 32'(n >= AF));
    chk("aempty0", 32'(ae0), 32'(n <= AE));
    chk("aempty1", 32'(ae1), 32'(n <= AE));
    chk("ovf0", 32'(ovf0), 32'(m_ovf));
    chk("ovf1", 32'(ovf1), 32'(m_ovf));
    chk("unf0", 32'(unf0), 32'(m_unf));
    chk("unf1", 32'(unf1), 32'(m_unf));
    chk("dout_std", 32'(dout0), 32'(m_dout));
    if (n > 0) chk("dout_fwft", 32'(dout1), 32'(q[0]));
  endtask

  task automatic cyc(input logic we, input logic [DW-1:0] d, input logic re,
                     input logic clr, input logic rn);
    bit was_full, was_empty;
    w_en = we; data_in = d; r_en = re; clr_err = clr; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_dout = '0;
    end else begin
      was_full = q.size() == DEPTH;
      was_empty = q.size() == 0;
      if (re && !was_empty) m_dout = q.pop_front();
      if (we && !was_full) q.push_back(d);
      m_ovf = (we && was_full) || (m_ovf && !clr);
      m_unf = (re && was_empty) || (m_unf && !clr);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    w_en = 0; r_en = 0; clr_err = 0; data_in = '0; rst_n = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0, 0, 1);
    cyc(1, 8'hEE, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 1, 0, 1);
    chk("hold_after_underflow", 32'(dout0), 32'h0F);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(1, DW'(8'h40 + i), 0, 0, 1);
    for (int i = 0; i < 40; i++) cyc(1, DW'(8'h50 + i), 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 8'hA5, 0, 0, 1);
    chk("fwft_first_word", 32'(dout1), 32'hA5);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("fwft_popped_empty", 32'(empty1), 32'h1);
    for (int i = 0; i < 10; i++) cyc(1, DW'(8'h90 + i), 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(1, 8'h33, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("no_stale_after_reset", 32'(dout0), 32'h33);
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0, 0, 1);
    cyc(1, 8'h77, 0, 1, 1);
    chk("set_beats_clear", 32'(ovf0), 32'h1);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) >= 2));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
